multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Cycle sequencer for the multi-cycle RV32I core. It steps the IF/ID/EX/MEM/WB states per instruction class, drives the shared-datapath write strobes (PC, IR, register file, data memory), and handshakes with instruction and data memory. It also counts retired instructions, supports halt-after-retire, and traps on illegal opcodes and memory timeouts. It sits beside the combinational decode control, whose RegWrite/MemWrite are ANDed with this block's enables.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 255, max stall cycles waiting on imem_ready/dmem_ready before bus error (1..2^16-1)

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
opcode  in  7  opcode from instruction register; valid from ID state onward
halt  in  1  request stop after the current instruction retires
imem_ready  in  1  instruction memory data valid / accept
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory access request
dmem_we  out  1  data access is a write (store)
IRWrite  out  1  latch instruction register
PCWrite  out  1  update PC (retire strobe)
RegWrite_en  out  1  register-file write enable gate
state  out  3  current state: IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5 ERR=7
retire  out  1  one-cycle pulse per retired instruction
inst_count  out  CNT_W  retired-instruction count
illegal  out  1  sticky: illegal opcode trap
bus_err  out  1  sticky: memory timeout trap

Behaviour:
- Reset (RSTn=0, async): state=IF, run_q=0, cls=0, wait_cnt=0, inst_count=0, illegal=0, bus_err=0. All request and strobe outputs are 0 while RSTn=0 or run_q=0.
- run_q sets on the first CLK edge after RSTn rises. Fetch starts the cycle after that.
- Opcode classes: ALU (0110011, 0010011, 0110111, 0010111), LOAD 0000011, STORE 0100011, BRANCH 1100011, JUMP (1101111, 1100111). Any other value is illegal.
- cls register: loaded from opcode in ID. Later states use cls only, so opcode changes after ID are ignored.
- IF:
  - imem_req=1.
  - imem_ready=1: IRWrite=1 that cycle, next state ID.
  - imem_ready=0: stay in IF.
- ID:
  - illegal opcode: next state ERR, illegal:=1.
  - JUMP: next state WB.
  - otherwise: next state EX.
- EX:
  - ALU: next state WB.
  - LOAD or STORE: next state MEM.
  - BRANCH: retire, next state IF.
- MEM:
  - dmem_req=1; dmem_we=1 only when cls=STORE.
  - dmem_ready=1: LOAD goes to WB; STORE retires and goes to IF.
  - dmem_ready=0: stay in MEM.
- WB: RegWrite_en=1, retire, next state IF.
- Retire cycle: PCWrite=1, retire=1, inst_count+=1 at the edge ending the cycle. inst_count wraps modulo 2^CNT_W.
- Halt: if halt=1 in a retire cycle, next state is HALT instead of IF. HALT drives all strobes 0. It moves to IF the cycle after halt=0. halt outside a retire cycle has no effect until the next retire.
- Timeout:
  - wait_cnt clears on entry to IF or MEM and increments each cycle in IF/MEM with the relevant ready=0.
  - If ready=0 while wait_cnt==MEM_TIMEOUT-1: next state ERR, bus_err:=1, no strobe that cycle.
  - A ready arriving in that same cycle wins: no error.
- ERR: terminal until reset. All strobes 0; illegal/bus_err hold.
- Outputs are combinational from state, cls, run_q and the ready inputs only. No dependency on opcode except in ID.
- Latency with zero-wait memory (cycles per instruction): ALU 4, LOAD 5, STORE 4, BRANCH 3, JUMP 3.
- Reset mid-instruction aborts immediately. No strobes fire after RSTn falls.

Test Plan:
- Reset release, then opcode=0110011 with imem_ready=1 held -> state 0,1,2,4; IRWrite in cycle 1, RegWrite_en+PCWrite+retire in cycle 4; inst_count=1.
- LOAD with dmem_ready low 3 cycles in MEM -> MEM held 4 cycles, dmem_req=1, dmem_we=0, then WB; total 8 cycles; inst_count increments once.
- STORE then BRANCH then JAL, zero-wait -> 4, 3, 3 cycles; dmem_we=1 only in STORE MEM; RegWrite_en only in JAL WB; inst_count=3.
- opcode=7'b1111111 in ID -> state 7, illegal=1, PCWrite never asserts, state stays 7 until RSTn low.
- MEM_TIMEOUT=4, imem_ready=0 forever -> ERR entered after 4 IF cycles, bus_err=1. Repeat with ready=1 on the 4th cycle -> IRWrite, no error.
- halt=1 during an ALU WB -> state 5 next; release halt -> IF the next cycle. CNT_W=3 with 9 retires -> inst_count=1.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: steps IF/ID/EX/MEM/WB per instruction class,
// drives datapath strobes, counts retires, and traps on bad opcodes/timeouts.
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [6:0]       opcode,
  input  logic             halt,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite_en,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] inst_count,
  output logic             illegal,
  output logic             bus_err
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JUMP   = 3'd4,
    C_ILL    = 3'd5
  } cls_t;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      st_q, st_d;
  cls_t        cls_q, cls_d, dec;
  logic        run_q;
  logic [15:0] wait_q, wait_d;
  logic        ill_d, berr_d;
  logic        ret, tmo, stall;

  always_comb begin
    unique case (opcode)
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111: dec = C_ALU;
      7'b0000011: dec = C_LOAD;
      7'b0100011: dec = C_STORE;
      7'b1100011: dec = C_BRANCH;
      7'b1101111,
      7'b1100111: dec = C_JUMP;
      default:    dec = C_ILL;
    endcase
  end

  always_comb begin
    st_d        = st_q;
    cls_d       = cls_q;
    ill_d       = illegal;
    berr_d      = bus_err;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite_en = 1'b0;
    ret         = 1'b0;
    stall       = 1'b0;
    tmo         = (wait_q == TMO_LAST);
    if (run_q) begin
      unique case (st_q)
        S_IF: begin
          imem_req = 1'b1;
          stall    = !imem_ready;
          if (imem_ready) begin
            IRWrite = 1'b1;
            st_d    = S_ID;
          end else if (tmo) begin
            st_d   = S_ERR;
            berr_d = 1'b1;
          end
        end
        S_ID: begin
          cls_d = dec;
          unique case (dec)
            C_ILL: begin
              st_d  = S_ERR;
              ill_d = 1'b1;
            end
            C_JUMP:  st_d = S_WB;
            default: st_d = S_EX;
          endcase
        end
        S_EX: begin
          unique case (cls_q)
            C_ALU:           st_d = S_WB;
            C_LOAD, C_STORE: st_d = S_MEM;
            C_BRANCH:        ret  = 1'b1;
            default:         st_d = S_ERR;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          stall    = !dmem_ready;
          if (dmem_ready) begin
            if (cls_q == C_STORE) ret = 1'b1;
            else                  st_d = S_WB;
          end else if (tmo) begin
            st_d   = S_ERR;
            berr_d = 1'b1;
          end
        end
        S_WB: begin
          RegWrite_en = 1'b1;
          ret         = 1'b1;
        end
        S_HALT: begin
          if (!halt) st_d = S_IF;
        end
        S_ERR:   st_d = S_ERR;
        default: st_d = S_ERR;
      endcase
      // halt is only honoured at the retire boundary
      if (ret) st_d = halt ? S_HALT : S_IF;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (run_q) begin
      if (st_d != st_q) wait_d = '0;
      else if (stall)   wait_d = wait_q + 16'd1;
    end
  end

  assign PCWrite = ret;
  assign retire  = ret;
  assign state   = st_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q       <= S_IF;
      cls_q      <= C_ALU;
      run_q      <= 1'b0;
      wait_q     <= '0;
      inst_count <= '0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      st_q    <= st_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      illegal <= ill_d;
      bus_err <= berr_d;
      if (ret) inst_count <= inst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction timeline model checked
// cycle by cycle under random waits, opcodes, halts and traps.
module tb_multicycle_sequencer;

  localparam int CNT_W = 3;
  localparam int TMO   = 4;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JMP = 4, K_ILL = 5;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic [6:0]       opcode;
  logic             halt;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite_en;
  logic [2:0]       state;
  logic             retire;
  logic [CNT_W-1:0] inst_count;
  logic             illegal;
  logic             bus_err;

  always #5 CLK = ~CLK;

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .halt(halt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite_en(RegWrite_en),
    .state(state), .retire(retire), .inst_count(inst_count),
    .illegal(illegal), .bus_err(bus_err)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  bit exp_ill  = 1'b0;
  bit exp_berr = 1'b0;

  logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0110111,
                            7'b0010111, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic int kind(input logic [6:0] o);
    case (o)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111, 7'b1100111: return K_JMP;
      default: return K_ILL;
    endcase
  endfunction

  // stb = {imem_req, dmem_req, dmem_we, IRWrite, PCWrite, RegWrite_en, retire}
  task automatic step(input string tag, input int st, input logic [6:0] stb,
                      input logic [6:0] opc, input logic h,
                      input logic ir, input logic dr);
    logic [31:0] got, exp;
    opcode = opc; halt = h; imem_ready = ir; dmem_ready = dr;
    #1;
    got = 32'({state, imem_req, dmem_req, dmem_we, IRWrite, PCWrite,
               RegWrite_en, retire, illegal, bus_err, inst_count});
    exp = 32'({st[2:0], stb, exp_ill, exp_berr, exp_cnt[CNT_W-1:0]});
    check(tag, got, exp);
    @(posedge CLK);
    if (stb[0]) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    exp_cnt = 0; exp_ill = 1'b0; exp_berr = 1'b0;
    step("rst_async", 0, 7'b0, r7(), rb(), 1'b1, 1'b1);
    step("rst_hold", 0, 7'b0, r7(), rb(), 1'b1, 1'b1);
    RSTn = 1'b1;
    step("run_q_gap", 0, 7'b0, r7(), rb(), 1'b1, 1'b1);
  endtask

  task automatic err_idle(input int n);
    for (int i = 0; i < n; i++)
      step("err_hold", 7, 7'b0, r7(), rb(), rb(), rb());
  endtask

  // hk < 0: no halt at retire; otherwise halt stays high hk cycles in HALT
  task automatic instr(input logic [6:0] opc, input int iw, input int dw,
                       input int hk, output bit err);
    int   k;
    logic hr;
    logic sw;
    k   = kind(opc);
    hr  = (hk >= 0);
    err = 1'b0;
    for (int i = 0; i <= iw; i++) begin
      if (i == iw) begin
        step("if_fetch", 0, 7'b1001000, r7(), rb(), 1'b1, rb());
      end else begin
        step("if_wait", 0, 7'b1000000, r7(), rb(), 1'b0, rb());
        if (i == TMO - 1) begin
          exp_berr = 1'b1; err = 1'b1; return;
        end
      end
    end
    step("id", 1, 7'b0, opc, rb(), rb(), rb());
    if (k == K_ILL) begin
      exp_ill = 1'b1; err = 1'b1; return;
    end
    if (k == K_BR) begin
      step("ex_branch", 2, 7'b0000101, r7(), hr, rb(), rb());
    end else if (k != K_JMP) begin
      step("ex", 2, 7'b0, r7(), rb(), rb(), rb());
    end
    if (k == K_LD || k == K_ST) begin
      sw = (k == K_ST);
      for (int i = 0; i <= dw; i++) begin
        if (i == dw) begin
          if (sw) step("mem_st", 3, 7'b0110101, r7(), hr, rb(), 1'b1);
          else    step("mem_ld", 3, 7'b0100000, r7(), rb(), rb(), 1'b1);
        end else begin
          step("mem_wait", 3, {2'b01, sw, 4'b0}, r7(), rb(), rb(), 1'b0);
          if (i == TMO - 1) begin
            exp_berr = 1'b1; err = 1'b1; return;
          end
        end
      end
    end
    if (k == K_ALU || k == K_LD || k == K_JMP)
      step("wb", 4, 7'b0000111, r7(), hr, rb(), rb());
    if (hr) begin
      for (int i = 0; i < hk; i++)
        step("halt_hold", 5, 7'b0, r7(), 1'b1, rb(), rb());
      step("halt_rel", 5, 7'b0, r7(), 1'b0, rb(), rb());
    end
  endtask

  bit err;
  int iw, dw, hk;
  logic [6:0] opc;

  initial begin
    RSTn = 1'b0; opcode = '0; halt = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge CLK);
    do_reset();

    instr(7'b0110011, 0, 0, -1, err);
    check("cnt_alu", 32'(inst_count), 32'd1);
    instr(7'b0000011, 0, 3, -1, err);
    check("cnt_load", 32'(inst_count), 32'd2);
    instr(7'b0100011, 0, 0, -1, err);
    instr(7'b1100011, 0, 0, -1, err);
    instr(7'b1101111, 0, 0, -1, err);
    check("cnt_mix", 32'(inst_count), 32'd5);
    instr(7'b0110011, 0, 0, 2, err);
    instr(7'b0010011, 3, 0, -1, err);
    check("if_ready_wins", 32'(bus_err), 32'd0);

    instr(7'b1111111, 0, 0, -1, err);
    err_idle(4);
    check("illegal_flag", 32'(illegal), 32'd1);
    do_reset();

    instr(7'b0110011, 20, 0, -1, err);
    err_idle(3);
    check("if_timeout", 32'(bus_err), 32'd1);
    do_reset();

    instr(7'b0000011, 0, 9, -1, err);
    err_idle(2);
    do_reset();

    for (int i = 0; i < 9; i++) instr(7'b0110111, 0, 0, -1, err);
    check("cnt_wrap", 32'(inst_count), 32'd1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) opc = r7();
      else opc = legal[$urandom_range(0, 8)];
      iw = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6)
                                        : $urandom_range(0, 3);
      dw = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6)
                                        : $urandom_range(0, 3);
      hk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
      instr(opc, iw, dw, hk, err);
      if (err) begin
        err_idle(2);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
